// File: rtl/ifu_seq_if.sv
// ----------------------------------------------------------------------------
// ifu_seq_if -- instruction-memory request/acknowledge bus.
//
//   imem_req    fetch request, held high until imem_ack
//   imem_addr   fetch address, valid while imem_req is high
//   imem_rdata  instruction word, valid with imem_ack
//   imem_ack    one-cycle acknowledge from instruction memory
//
// Modports: master = fetch unit, slave = instruction memory.
// ----------------------------------------------------------------------------
interface ifu_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/ifu_seq.sv
// ----------------------------------------------------------------------------
// ifu_seq -- instruction fetch sequencer.
//
// Holds the architectural PC, fetches one instruction at a time over a
// request/acknowledge memory bus, presents it to decode and, when the control
// path signals commit, computes the next PC from the 3-bit next-PC select.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   npc_sel       000 seq, 001 beq, 010 jal, 011 j, 100 jr, others seq
//   zero          ALU equality result, qualifies beq
//   imm16         branch offset field of the current instruction
//   target26      jump index field of the current instruction
//   rs_data       register rs value, jr target
//   commit        current instruction done; sample npc inputs and advance
//   imem          instruction-memory bus (ifu_seq_if.master)
//   instr         registered instruction for decode
//   instr_valid   instr holds the instruction at pc
//   pc            address of the current instruction
//   pc_plus4      pc+4, combinational; JAL link value
//   fault         misaligned jr flag (tied 0 unless IFU_ALIGN_CHECK_EN)
//
// Build option: define IFU_ALIGN_CHECK_EN to redirect a misaligned jr to
// TRAP_PC and raise fault until the next commit.
// ----------------------------------------------------------------------------
module ifu_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        npc_sel,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    input  logic [31:0]       rs_data,
    input  logic              commit,
    ifu_seq_if.master         imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    fetchState_t state, nextState;

    logic        takeAck;
    logic        takeCommit;
    logic [31:0] branchOffset;
    logic [31:0] npc;
    logic [31:0] npcFinal;

    // An ack counts only while a request is outstanding; commit only once the
    // instruction is held, so a same-cycle commit in WAIT is dropped.
    assign takeAck    = (state != HOLD) && imem.imem_ack;
    assign takeCommit = (state == HOLD) && commit;

    assign pc_plus4     = pc + 32'd4;
    assign branchOffset = {{14{imm16[15]}}, imm16, 2'b00};

    // ---------------- state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= nextState;
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; a path that leaves nextState unassigned would infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            FETCH:   nextState = takeAck ? HOLD : WAIT;
            WAIT:    if (takeAck) nextState = HOLD;
            HOLD:    if (takeCommit) nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    // ---------------- output logic ----------------
    // The request is gated by rst_n so it drops immediately when reset is
    // asserted, abandoning any outstanding fetch.
    always_comb begin
        imem.imem_req  = rst_n && (state != HOLD);
        imem.imem_addr = pc;
    end

    // ---------------- next-PC selection ----------------
    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            3'b001:         npc = zero ? (pc_plus4 + branchOffset) : pc_plus4;
            3'b010, 3'b011: npc = {pc_plus4[31:28], target26, 2'b00};
            3'b100:         npc = rs_data;
            default:        npc = pc_plus4;
        endcase
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic misalignJr;

    // Only jr can produce an unaligned target; all other sources are
    // word-aligned by construction.
    assign misalignJr = (npc_sel == 3'b100) && (rs_data[1:0] != 2'b00);
    assign npcFinal   = misalignJr ? TRAP_PC : npc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fault <= 1'b0;
        else if (takeCommit) fault <= misalignJr;
    end
`else
    logic unusedTrapPc;

    assign unusedTrapPc = ^TRAP_PC;
    assign npcFinal     = npc;
    assign fault        = 1'b0;
`endif

    // ---------------- PC and instruction registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (takeAck) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            if (takeCommit) begin
                pc          <= npcFinal;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_seq.sv
// ----------------------------------------------------------------------------
// tb_ifu_seq -- self-checking bench for ifu_seq.
//
// A table of commit vectors walks the PC through every next-PC source, with a
// fetch of varying latency after each commit. Hand-written sequences cover a
// long stall with a commit pulsed in WAIT, commit and ack in the same cycle,
// and reset asserted mid-WAIT. Inputs are driven and outputs sampled on the
// falling clock edge. Expected values follow IFU_ALIGN_CHECK_EN if defined.
// ----------------------------------------------------------------------------
module tb_ifu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  npc_sel;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data;
    logic        commit;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    ifu_seq_if imemBus ();

    ifu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_sel     (npc_sel),
        .zero        (zero),
        .imm16       (imm16),
        .target26    (target26),
        .rs_data     (rs_data),
        .commit      (commit),
        .imem        (imemBus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  sel;
        logic        zero;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] rs;
        logic [31:0] expPlus4;   // pc_plus4 before the commit
        logic [31:0] expPc;      // pc after the commit
        logic        expFault;   // fault after the commit
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called on a falling edge with a request pending. Waits 'delay' cycles
    // with the request held, then acks for one cycle with 'word'.
    task automatic doFetch(input int delay, input logic [31:0] word, input string tag);
        logic [31:0] addr0;
        addr0 = imemBus.imem_addr;
        check({tag, " req"}, 32'(imemBus.imem_req), 32'd1);
        for (int c = 0; c < delay; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s stall%0d req", tag, c), 32'(imemBus.imem_req), 32'd1);
            check($sformatf("%s stall%0d addr", tag, c), imemBus.imem_addr, addr0);
            check($sformatf("%s stall%0d valid", tag, c), 32'(instr_valid), 32'd0);
        end
        imemBus.imem_ack   = 1'b1;
        imemBus.imem_rdata = word;
        @(posedge clk);
        @(negedge clk);
        imemBus.imem_ack   = 1'b0;
        imemBus.imem_rdata = '0;
        check({tag, " instr"}, instr, word);
        check({tag, " valid"}, 32'(instr_valid), 32'd1);
        check({tag, " req idle"}, 32'(imemBus.imem_req), 32'd0);
    endtask

    // Called on a falling edge in HOLD. Commits once and checks the new PC.
    task automatic doCommit(input vec_t v, input string tag);
        check({tag, " pc_plus4"}, pc_plus4, v.expPlus4);
        npc_sel  = v.sel;
        zero     = v.zero;
        imm16    = v.imm;
        target26 = v.tgt;
        rs_data  = v.rs;
        commit   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
        check({tag, " pc"}, pc, v.expPc);
        check({tag, " addr"}, imemBus.imem_addr, v.expPc);
        check({tag, " valid drop"}, 32'(instr_valid), 32'd0);
        check({tag, " fault"}, 32'(fault), 32'(v.expFault));
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic z, input logic [15:0] imm,
                                input logic [25:0] tgt, input logic [31:0] rs,
                                input logic [31:0] p4, input logic [31:0] npc, input logic f);
        vec_t v;
        v.sel = sel; v.zero = z; v.imm = imm; v.tgt = tgt; v.rs = rs;
        v.expPlus4 = p4; v.expPc = npc; v.expFault = f;
        return v;
    endfunction

    initial begin
        logic [31:0] curPc;
        vec_t        seqV;

        // Seq entries carry noise in the unused fields to catch mis-selection.
        vecs[0]  = mk(3'b000, 1'b1, 16'h7FFF, 26'h3FF_FFFF, 32'h1234_5678, 32'h0000_3004, 32'h0000_3004, 1'b0);
        vecs[1]  = mk(3'b000, 1'b1, 16'h7FFF, 26'h3FF_FFFF, 32'h1234_5678, 32'h0000_3008, 32'h0000_3008, 1'b0);
        vecs[2]  = mk(3'b000, 1'b0, 16'h0100, 26'h000_0001, 32'h0000_0000, 32'h0000_300C, 32'h0000_300C, 1'b0);
        vecs[3]  = mk(3'b000, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0000_3010, 32'h0000_3010, 1'b0);
        vecs[4]  = mk(3'b001, 1'b1, 16'hFFFC, 26'h000_0000, 32'h0000_0000, 32'h0000_3014, 32'h0000_3004, 1'b0);
        vecs[5]  = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3010, 32'h0000_3008, 32'h0000_3010, 1'b0);
        vecs[6]  = mk(3'b001, 1'b0, 16'hFFFC, 26'h000_0000, 32'h0000_0000, 32'h0000_3014, 32'h0000_3014, 1'b0);
        vecs[7]  = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3020, 32'h0000_3018, 32'h0000_3020, 1'b0);
        vecs[8]  = mk(3'b011, 1'b0, 16'h0000, 26'h000_0C10, 32'h0000_0000, 32'h0000_3024, 32'h0000_3040, 1'b0);
        vecs[9]  = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3020, 32'h0000_3044, 32'h0000_3020, 1'b0);
        vecs[10] = mk(3'b010, 1'b1, 16'h1234, 26'h000_0C10, 32'h0000_0000, 32'h0000_3024, 32'h0000_3040, 1'b0);
        vecs[11] = mk(3'b001, 1'b1, 16'hFFFF, 26'h000_0000, 32'h0000_0000, 32'h0000_3044, 32'h0000_3040, 1'b0);
        vecs[12] = mk(3'b101, 1'b1, 16'h0100, 26'h3FF_FFFF, 32'h1234_5678, 32'h0000_3044, 32'h0000_3044, 1'b0);
        vecs[13] = mk(3'b111, 1'b1, 16'h0100, 26'h3FF_FFFF, 32'h1234_5678, 32'h0000_3048, 32'h0000_3048, 1'b0);
        vecs[14] = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3100, 32'h0000_304C, 32'h0000_3100, 1'b0);
        vecs[15] = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'hFFFF_FFFC, 32'h0000_3104, 32'hFFFF_FFFC, 1'b0);
        vecs[16] = mk(3'b000, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
`ifdef IFU_ALIGN_CHECK_EN
        vecs[17] = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3102, 32'h0000_0004, 32'h0000_4180, 1'b1);
        vecs[18] = mk(3'b000, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0000_4184, 32'h0000_4184, 1'b0);
        vecs[19] = mk(3'b001, 1'b1, 16'h0004, 26'h000_0000, 32'h0000_0000, 32'h0000_4188, 32'h0000_4198, 1'b0);
`else
        vecs[17] = mk(3'b100, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_3102, 32'h0000_0004, 32'h0000_3102, 1'b0);
        vecs[18] = mk(3'b000, 1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0000_3106, 32'h0000_3106, 1'b0);
        vecs[19] = mk(3'b001, 1'b1, 16'h0004, 26'h000_0000, 32'h0000_0000, 32'h0000_310A, 32'h0000_311A, 1'b0);
`endif

        rst_n = 1'b0;
        npc_sel = '0; zero = 1'b0; imm16 = '0; target26 = '0; rs_data = '0; commit = 1'b0;
        imemBus.imem_ack = 1'b0;
        imemBus.imem_rdata = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset pc", pc, 32'h0000_3000);
        check("reset instr", instr, 32'h0);
        check("reset valid", 32'(instr_valid), 32'd0);
        check("reset req", 32'(imemBus.imem_req), 32'd0);
        check("reset fault", 32'(fault), 32'd0);

        // ---- first fetch, ack one cycle after the request ----
        rst_n = 1'b1;
        #1;
        check("first addr", imemBus.imem_addr, 32'h0000_3000);
        doFetch(1, 32'h3C01_1234, "first");
        check("first pc_plus4", pc_plus4, 32'h0000_3004);

        // ---- table of commits, each followed by a fetch ----
        for (int i = 0; i < NVEC; i++) begin
            doCommit(vecs[i], $sformatf("v%0d", i));
            doFetch(i % 3, 32'hA500_0000 + 32'(i), $sformatf("v%0d fetch", i));
        end
        curPc = vecs[NVEC-1].expPc;

        // ---- commit pulsed in WAIT is ignored; then a 5-cycle stall ----
        seqV = mk(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, curPc + 32'd4, curPc + 32'd4, 1'b0);
        doCommit(seqV, "pre-stall");
        curPc = curPc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        npc_sel = 3'b100; rs_data = 32'hDEAD_0000; commit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
        check("wait-commit pc", pc, curPc);
        check("wait-commit req", 32'(imemBus.imem_req), 32'd1);
        doFetch(5, 32'h1234_5678, "stall");
        check("stall pc", pc, curPc);

        // ---- commit and ack in the same WAIT cycle: ack wins ----
        seqV = mk(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, curPc + 32'd4, curPc + 32'd4, 1'b0);
        doCommit(seqV, "pre-collide");
        curPc = curPc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        imemBus.imem_ack = 1'b1; imemBus.imem_rdata = 32'hCAFE_F00D;
        npc_sel = 3'b100; rs_data = 32'hDEAD_0000; commit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imemBus.imem_ack = 1'b0; imemBus.imem_rdata = '0; commit = 1'b0;
        check("collide pc", pc, curPc);
        check("collide instr", instr, 32'hCAFE_F00D);
        check("collide valid", 32'(instr_valid), 32'd1);
        check("collide req", 32'(imemBus.imem_req), 32'd0);

        // ---- reset asserted mid-WAIT ----
        seqV = mk(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, curPc + 32'd4, curPc + 32'd4, 1'b0);
        doCommit(seqV, "pre-reset");
        @(posedge clk);
        @(negedge clk);
        check("midwait req", 32'(imemBus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwait rst pc", pc, 32'h0000_3000);
        check("midwait rst req", 32'(imemBus.imem_req), 32'd0);
        check("midwait rst valid", 32'(instr_valid), 32'd0);
        check("midwait rst instr", instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset addr", imemBus.imem_addr, 32'h0000_3000);
        doFetch(2, 32'h0BAD_BEEF, "post-reset");
        check("post-reset pc_plus4", pc_plus4, 32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
